// File: rtl/serial_nibble_comparator.sv
// Compares two WIDTH-bit unsigned operands one nibble at a time (MSB first) through an external 4-bit comparator.
// Latency: result valid 1..N edges after accept (N with EARLY_EXIT=0); one operation in flight at a time.
// Backpressure: o_READY only in IDLE; the result is held in DONE until i_READY is seen.
module serial_nibble_comparator #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_VALID,
    output logic             o_READY,
    input  logic [WIDTH-1:0] i_OPERAND_A,
    input  logic [WIDTH-1:0] i_OPERAND_B,
    output logic [3:0]       o_NIBBLE_A,
    output logic [3:0]       o_NIBBLE_B,
    input  logic             i_CMP_GT,
    input  logic             i_CMP_EQ,
    input  logic             i_CMP_LT,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic             o_GT,
    output logic             o_EQ,
    output logic             o_LT,
    output logic             o_ERROR
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, COMPARE = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] op_a, op_b;
    logic [3:0]       nib_a, nib_b;
    logic             decided, dec_gt, dec_lt;
    logic             res_gt, res_eq, res_lt, res_err;
    logic             flags_ok, idx_last, accept, finish;

    assign flags_ok = ({i_CMP_GT, i_CMP_EQ, i_CMP_LT} == 3'b100) ||
                      ({i_CMP_GT, i_CMP_EQ, i_CMP_LT} == 3'b010) ||
                      ({i_CMP_GT, i_CMP_EQ, i_CMP_LT} == 3'b001);
    assign idx_last = (idx == '0);
    assign accept   = (state == IDLE) && i_VALID;
    assign finish   = (state == COMPARE) && (state_nxt == DONE);

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_VALID) state_nxt = COMPARE;
            // A malformed flag set always terminates, even in full-scan mode.
            COMPARE: if (!flags_ok || idx_last || (EARLY_EXIT && !decided && !i_CMP_EQ))
                         state_nxt = DONE;
            DONE:    if (i_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The first decision is kept in dec_* and only published on the way into DONE,
    // so the visible result never changes while a comparison is in progress.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            idx     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            dec_lt  <= 1'b0;
            res_gt  <= 1'b0;
            res_eq  <= 1'b0;
            res_lt  <= 1'b0;
            res_err <= 1'b0;
        end else begin
            if (accept) begin
                op_a    <= i_OPERAND_A;
                op_b    <= i_OPERAND_B;
                idx     <= IW'(N - 1);
                decided <= 1'b0;
                dec_gt  <= 1'b0;
                dec_lt  <= 1'b0;
                res_err <= 1'b0;
            end
            if (state == COMPARE) begin
                if (!idx_last) idx <= idx - 1'b1;
                if (flags_ok && !decided && !i_CMP_EQ) begin
                    decided <= 1'b1;
                    dec_gt  <= i_CMP_GT;
                    dec_lt  <= i_CMP_LT;
                end
            end
            if (finish) begin
                if (!flags_ok) begin
                    res_err <= 1'b1;
                    res_gt  <= 1'b0;
                    res_eq  <= 1'b0;
                    res_lt  <= 1'b0;
                end else if (decided) begin
                    res_gt  <= dec_gt;
                    res_eq  <= 1'b0;
                    res_lt  <= dec_lt;
                end else begin
                    res_gt  <= i_CMP_GT;
                    res_eq  <= i_CMP_EQ;
                    res_lt  <= i_CMP_LT;
                end
            end
        end
    end

    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                nib_a = op_a[4*i +: 4];
                nib_b = op_b[4*i +: 4];
            end
        end
    end

    always_comb begin
        o_READY    = 1'b0;
        o_VALID    = 1'b0;
        o_NIBBLE_A = 4'h0;
        o_NIBBLE_B = 4'h0;
        case (state)
            IDLE:    o_READY = 1'b1;
            COMPARE: begin
                o_NIBBLE_A = nib_a;
                o_NIBBLE_B = nib_b;
            end
            DONE:    o_VALID = 1'b1;
            default: ;
        endcase
    end

    assign o_GT    = res_gt;
    assign o_EQ    = res_eq;
    assign o_LT    = res_lt;
    assign o_ERROR = res_err;
endmodule

// File: tb/tb_serial_nibble_comparator.sv
// Bench for serial_nibble_comparator: instance 0 uses early exit, instance 1 scans every nibble.
// Each instance has a behavioural 4-bit comparator in the loop with a fault-injection override.
module tb_serial_nibble_comparator;
    localparam logic [3:0] R_GT = 4'b1000, R_EQ = 4'b0100, R_LT = 4'b0010, R_ER = 4'b0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       vld, rdy, inj;
    logic [1:0][15:0] opa, opb;
    wire  [1:0]       ordy, ovld, gt, eq, lt, err, cgt, ceq, clt;
    wire  [1:0][3:0]  na, nb;

    int checks   = 0;
    int failures = 0;

    serial_nibble_comparator #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_ee (
        .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(vld[0]), .o_READY(ordy[0]),
        .i_OPERAND_A(opa[0]), .i_OPERAND_B(opb[0]), .o_NIBBLE_A(na[0]), .o_NIBBLE_B(nb[0]),
        .i_CMP_GT(cgt[0]), .i_CMP_EQ(ceq[0]), .i_CMP_LT(clt[0]), .o_VALID(ovld[0]),
        .i_READY(rdy[0]), .o_GT(gt[0]), .o_EQ(eq[0]), .o_LT(lt[0]), .o_ERROR(err[0]));

    serial_nibble_comparator #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_full (
        .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(vld[1]), .o_READY(ordy[1]),
        .i_OPERAND_A(opa[1]), .i_OPERAND_B(opb[1]), .o_NIBBLE_A(na[1]), .o_NIBBLE_B(nb[1]),
        .i_CMP_GT(cgt[1]), .i_CMP_EQ(ceq[1]), .i_CMP_LT(clt[1]), .o_VALID(ovld[1]),
        .i_READY(rdy[1]), .o_GT(gt[1]), .o_EQ(eq[1]), .o_LT(lt[1]), .o_ERROR(err[1]));

    // inj forces GT and EQ together, which is never a legal comparator answer.
    for (genvar g = 0; g < 2; g++) begin : g_cmp
        assign cgt[g] = inj[g] | (na[g] > nb[g]);
        assign ceq[g] = inj[g] | (na[g] == nb[g]);
        assign clt[g] = ~inj[g] & (na[g] < nb[g]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] nib(input logic [15:0] v, input int pos);
        return 4'((v >> (4 * pos)) & 16'hF);
    endfunction

    function automatic int model_lat(input bit early, input logic [15:0] a, input logic [15:0] b);
        if (!early) return 4;
        for (int j = 0; j < 4; j++)
            if (nib(a, 3 - j) != nib(b, 3 - j)) return j + 1;
        return 4;
    endfunction

    function automatic logic [3:0] model_res(input logic [15:0] a, input logic [15:0] b);
        if (a > b) return R_GT;
        if (a < b) return R_LT;
        return R_EQ;
    endfunction

    task automatic txn(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input bit inject, input int hold, output int lat, output logic [3:0] res);
        logic [3:0] qa[$];
        logic [3:0] qb[$];
        int e;
        @(negedge clk);
        chk("ready_idle", 32'(ordy[sel]), 32'd1);
        vld[sel] = 1'b1; opa[sel] = a; opb[sel] = b; inj[sel] = inject;
        @(posedge clk);
        @(negedge clk);
        vld[sel] = 1'b0;
        opa[sel] = 16'($urandom);
        opb[sel] = 16'($urandom);
        chk("err_clear_on_accept", 32'(err[sel]), 32'd0);
        chk("busy_not_ready", 32'(ordy[sel]), 32'd0);
        e = 0;
        while (!ovld[sel] && e < 20) begin
            qa.push_back(na[sel]);
            qb.push_back(nb[sel]);
            @(posedge clk);
            e++;
            @(negedge clk);
            inj[sel] = 1'b0;
        end
        lat = e;
        res = {gt[sel], eq[sel], lt[sel], err[sel]};
        if (!ovld[sel]) chk("valid_timeout", 32'd0, 32'd1);
        if (!inject)
            for (int j = 0; j < qa.size() && j < 4; j++) begin
                chk("nibble_a", 32'(qa[j]), 32'(nib(a, 3 - j)));
                chk("nibble_b", 32'(qb[j]), 32'(nib(b, 3 - j)));
            end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(ovld[sel]), 32'd1);
            chk("hold_not_ready", 32'(ordy[sel]), 32'd0);
            chk("hold_result", 32'({gt[sel], eq[sel], lt[sel], err[sel]}), 32'(res));
        end
        rdy[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy[sel] = 1'b0;
        chk("release_ready", 32'(ordy[sel]), 32'd1);
        chk("release_valid", 32'(ovld[sel]), 32'd0);
    endtask

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        int          lat;
        logic [3:0]  res;
    } vec_t;

    initial begin
        vec_t       vecs[8];
        int         lat;
        logic [3:0] res;
        bit         seen;
        int         sel;
        logic [15:0] a, b;

        vecs[0] = '{0, 16'hD3A5, 16'hD3A5, 4, R_EQ};
        vecs[1] = '{0, 16'h1D00, 16'h1F00, 2, R_LT};
        vecs[2] = '{1, 16'h1D00, 16'h1F00, 4, R_LT};
        vecs[3] = '{1, 16'h2100, 16'h1F00, 4, R_GT};
        vecs[4] = '{0, 16'h0000, 16'hFFFF, 1, R_LT};
        vecs[5] = '{0, 16'hFFFF, 16'hFFFE, 4, R_GT};
        vecs[6] = '{1, 16'h0000, 16'h0000, 4, R_EQ};
        vecs[7] = '{0, 16'h8000, 16'h7FFF, 1, R_GT};

        rst_n = 1'b0; vld = '0; rdy = '0; inj = '0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ordy), 32'h3);
        chk("rst_valid", 32'(ovld), 32'h0);
        chk("rst_results", 32'({gt, eq, lt, err}), 32'h0);
        chk("rst_nibbles", 32'({na, nb}), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            txn(vecs[i].sel, vecs[i].a, vecs[i].b, 1'b0, 0, lat, res);
            chk("vec_latency", 32'(lat), 32'(vecs[i].lat));
            chk("vec_result", 32'(res), 32'(vecs[i].res));
        end

        txn(0, 16'h1D00, 16'h1F00, 1'b0, 3, lat, res);
        chk("hold3_result", 32'(res), 32'(R_LT));

        txn(0, 16'h1234, 16'h1234, 1'b1, 0, lat, res);
        chk("inject_ee_latency", 32'(lat), 32'd1);
        chk("inject_ee_result", 32'(res), 32'(R_ER));
        txn(1, 16'h1234, 16'h1234, 1'b1, 1, lat, res);
        chk("inject_full_latency", 32'(lat), 32'd1);
        chk("inject_full_result", 32'(res), 32'(R_ER));
        txn(0, 16'h0042, 16'h0041, 1'b0, 0, lat, res);
        chk("post_error_result", 32'(res), 32'(R_GT));

        // Reset during the second compare cycle, with valid asserted on the reset edge.
        @(negedge clk);
        vld[0] = 1'b1; opa[0] = 16'hD3A5; opb[0] = 16'hD3A5;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; vld = 2'b11; rdy = 2'b11;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; vld = '0; rdy = '0;
        chk("midrst_ready", 32'(ordy), 32'h3);
        chk("midrst_valid", 32'(ovld), 32'h0);
        chk("midrst_results", 32'({gt, eq, lt, err}), 32'h0);
        chk("midrst_nibbles", 32'({na[0], nb[0]}), 32'h0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ovld[0]) seen = 1'b1;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);

        for (int t = 0; t < 150; t++) begin
            sel = int'($urandom_range(0, 1));
            a   = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (16'h1 << $urandom_range(0, 15));
                2:       b = {a[15:8], 8'($urandom)};
                default: b = 16'($urandom);
            endcase
            txn(sel, a, b, 1'b0, int'($urandom_range(0, 2)), lat, res);
            chk("rand_latency", 32'(lat), 32'(model_lat(sel == 0, a, b)));
            chk("rand_result", 32'(res), 32'(model_res(a, b)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_nibble_comparator.md
SERIAL_NIBBLE_COMPARATOR -- requirements
Module: serial_nibble_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 and at least 4; N = WIDTH/4 nibbles.
REQ-002 SHALL have parameter EARLY_EXIT, default 1; 1 = stop at first unequal nibble, 0 = always scan all N nibbles.
REQ-003 SHALL have port i_CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port i_RST_N  input  1  synchronous, active-low reset.
REQ-005 SHALL have port i_VALID  input  1  operand pair offered.
REQ-006 SHALL have port o_READY  output  1  block can accept an operand pair.
REQ-007 SHALL have port i_OPERAND_A  input  WIDTH  unsigned operand A.
REQ-008 SHALL have port i_OPERAND_B  input  WIDTH  unsigned operand B.
REQ-009 SHALL have port o_NIBBLE_A  output  4  current nibble of A, fed to the 4-bit comparator's A operand.
REQ-010 SHALL have port o_NIBBLE_B  output  4  current nibble of B, fed to the 4-bit comparator's B operand.
REQ-011 SHALL have ports i_CMP_GT, i_CMP_EQ, i_CMP_LT  input  1 each  combinational result returned by the 4-bit comparator for the presented nibbles.
REQ-012 SHALL have port o_VALID  output  1  result available.
REQ-013 SHALL have port i_READY  input  1  downstream accepts result.
REQ-014 SHALL have ports o_GT, o_EQ, o_LT  output  1 each  full-width result, A>B, A==B, A<B.
REQ-015 SHALL have port o_ERROR  output  1  comparator returned a non-one-hot flag set.

Function
REQ-016 SHALL implement states IDLE, COMPARE, DONE.
REQ-017 IDLE: o_READY=1. An edge with i_VALID=1 captures both operands, sets the index to N-1, and moves to COMPARE.
REQ-018 o_READY SHALL be 0 in COMPARE and DONE; there is no accept/result overlap.
REQ-019 COMPARE: o_NIBBLE_A/o_NIBBLE_B SHALL present bits [4*idx+3:4*idx] of the captured operands, processed MSB nibble first. In every other state they SHALL be 4'h0.
REQ-020 Comparator flags SHALL be sampled at each COMPARE edge.
REQ-021 If the flags are not exactly one-hot: set o_ERROR=1, clear o_GT/o_EQ/o_LT to 0, and go to DONE immediately, regardless of EARLY_EXIT.
REQ-022 First GT or LT flag seen: record it as the result. With EARLY_EXIT=1, go to DONE. With EARLY_EXIT=0, continue decrementing the index; the first decision is retained and later nibbles never override it.
REQ-023 EQ at idx=0 with no prior decision: result EQ, go to DONE. Otherwise EQ decrements the index.
REQ-024 Reaching idx=0 with EARLY_EXIT=0 SHALL go to DONE after that sample.
REQ-025 Latency: if the decision is made on the k-th COMPARE sample (k=1..N), o_VALID SHALL be 1 starting k edges after the accepting edge. With EARLY_EXIT=0, k=N always.
REQ-026 DONE: o_VALID=1. o_GT/o_EQ/o_LT/o_ERROR SHALL be exactly one-hot-or-error and stable until an edge with i_READY=1, which moves to IDLE.
REQ-027 Result outputs SHALL hold their last values in IDLE and COMPARE; they are meaningful only while o_VALID=1.
REQ-028 o_ERROR SHALL clear on the next operand accept.
REQ-029 Operand inputs SHALL be ignored outside the IDLE accept edge; changes during COMPARE SHALL NOT affect the result.

Reset
REQ-030 At any edge with i_RST_N=0, the block SHALL enter IDLE, clear the index, and drive o_READY=1 and o_VALID=0. o_GT/o_EQ/o_LT/o_ERROR SHALL be 0 and o_NIBBLE_A/o_NIBBLE_B SHALL be 4'h0.
REQ-031 Reset asserted during COMPARE or DONE SHALL abandon the operation with no result produced. Reset SHALL take priority over i_VALID and i_READY on the same edge.

Verification (WIDTH=16, bench instantiates the 4-bit comparator in the loop)
REQ-032 A=0xD3A5, B=0xD3A5, EARLY_EXIT=1 -> nibbles D/D, 3/3, A/A, 5/5 presented in order; o_VALID rises 4 edges after accept with o_EQ=1.
REQ-033 A=0x1D00, B=0x1F00, EARLY_EXIT=1 -> decision on nibble 2 (D vs F); o_VALID rises 2 edges after accept with o_LT=1.
REQ-034 Same operands, EARLY_EXIT=0 -> o_VALID rises 4 edges after accept, o_LT=1. Also A=0x2100, B=0x1F00 -> o_GT=1 with the first decision retained.
REQ-035 Hold i_READY=0 for 3 cycles in DONE -> o_VALID and the result stay stable and o_READY=0; release -> IDLE on the next edge, o_READY=1.
REQ-036 Bench forces i_CMP_GT=i_CMP_EQ=1 on the first sample -> o_ERROR=1 and o_GT=o_EQ=o_LT=0 one edge after accept; the next accept clears o_ERROR.
REQ-037 Assert i_RST_N=0 for one edge during the second COMPARE cycle -> IDLE, o_VALID=0, o_READY=1, all results 0, and no result is emitted.
